mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage between exe_stage and wb_stage. Accepts one instruction
//  per handshake from EXE, waits for the data-SRAM response on loads, extracts/extends
//  load data, and forwards {regW, waddr, wdata, pc} to WB. Drives the MEM forwarding and
//  load-use stall bus to the ID stage.
// PARAMETERS
//  EXE_TO_MEM_WD  74  exe_to_mem_bus width = {ld_en, ld_type[2:0], regW, waddr[4:0], alu_res[31:0], pc[31:0]}
//  MEM_TO_WB_WD   70  mem_to_wb_bus width  = {regW, waddr[4:0], wdata[31:0], pc[31:0]}
//  MEM_TO_ID_WD   40  mem_to_id_bus width  = {fwd_valid, ld_pending, regW_v, waddr[4:0], wdata[31:0]}
// PORTS
//  clk             in   1    clock
//  resetn          in   1    synchronous active-low reset
//  mem_allowin     out  1    MEM can accept from EXE this cycle
//  exe_to_mem_valid in  1    EXE holds a valid instruction
//  exe_to_mem_bus  in   74   EXE payload (fields above)
//  wb_allowin      in   1    WB can accept this cycle
//  mem_to_wb_valid out  1    MEM presents a completed instruction to WB
//  mem_to_wb_bus   out  70   WB payload (fields above)
//  mem_to_id_bus   out  40   forwarding/stall info for ID
//  data_sram_data_ok in 1    load response valid (one pulse per issued load)
//  data_sram_rdata in   32   load response word
// BEHAVIOUR
//  Reset: mem_valid=0, state=IDLE, rdata_buf invalid; mem_allowin=1, mem_to_wb_valid=0,
//   mem_to_id_bus=0. Payload regs are not reset.
//  Handshake: mem_ready_go = ~ld_en | (state==HOLD) | (state==WAIT & data_ok);
//   mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin);
//   mem_to_wb_valid = mem_valid & mem_ready_go. On mem_allowin: mem_valid<=exe_to_mem_valid;
//   payload latched only when mem_allowin & exe_to_mem_valid.
//  FSM (for loads only; non-loads stay IDLE, zero added latency):
//   IDLE->WAIT when a load is accepted. WAIT->IDLE on data_ok & wb_allowin (same-cycle pass).
//   WAIT->HOLD on data_ok & ~wb_allowin: rdata latched into rdata_buf. HOLD->IDLE on wb_allowin.
//   On a same-cycle transfer of a load and accept of a new load: stays/enters WAIT.
//  Load result uses data_ok ? data_sram_rdata : rdata_buf; byte/half lane = alu_res[1:0].
//   ld_type 000 W: word. 001 B: sign-ext byte. 010 H: sign-ext half (alu_res[1]).
//   011 BU / 100 HU: zero-ext. Other codes: word. Non-loads: wdata = alu_res.
//  data_ok while state!=WAIT (incl. post-reset stragglers) is ignored.
//  Forwarding: fwd_valid=mem_valid; regW_v=regW&mem_valid; waddr=mem_valid?waddr:0;
//   ld_pending = mem_valid & ld_en & ~mem_ready_go (ID must stall, not forward);
//   wdata = final writeback value when not pending.
//  Reset mid-operation: any in-flight instruction and buffered data discarded, back to IDLE.
// TESTING
//  ALU op regW=1 waddr=5 alu_res=0x1234 -> next cycle mem_to_wb_valid=1, wdata=0x1234, no stall.
//  ld.b alu_res[1:0]=2'b11, data_ok same cycle as valid, rdata=0x80FF_0000 -> wdata=0xFFFF_FF80.
//  ld.hu alu_res[1]=1, data_ok 3 cycles late, rdata=0xBEEF_0000 -> ld_pending=1 for 3 cycles,
//   mem_allowin=0, then wdata=0x0000_BEEF.
//  ld.w, data_ok with wb_allowin=0 -> HOLD, rdata_buf kept; wb_allowin=1 two cycles later
//   -> rdata delivered once, state IDLE.
//  Back-to-back loads with data_ok every cycle -> one retire per cycle, no bubbles.
//  resetn=0 during WAIT, then stray data_ok -> mem_to_wb_valid stays 0, state IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction from EXE, waits for the
// data-SRAM response on loads, aligns/extends load data and hands results to WB.
module mem_stage #(
  parameter int EXE_TO_MEM_WD = 74,
  parameter int MEM_TO_WB_WD  = 70,
  parameter int MEM_TO_ID_WD  = 40
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic                     mem_allowin,
  input  logic                     exe_to_mem_valid,
  input  logic [EXE_TO_MEM_WD-1:0] exe_to_mem_bus,
  input  logic                     wb_allowin,
  output logic                     mem_to_wb_valid,
  output logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0]  mem_to_id_bus,
  input  logic                     data_sram_data_ok,
  input  logic [31:0]              data_sram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                   state;
  logic                     mem_valid;
  logic [EXE_TO_MEM_WD-1:0] exe_bus_r;
  logic [31:0]              rdata_buf;

  logic        ld_en;
  logic [2:0]  ld_type;
  logic        reg_w;
  logic [4:0]  waddr;
  logic [31:0] alu_res;
  logic [31:0] pc;

  assign ld_en   = exe_bus_r[73];
  assign ld_type = exe_bus_r[72:70];
  assign reg_w   = exe_bus_r[69];
  assign waddr   = exe_bus_r[68:64];
  assign alu_res = exe_bus_r[63:32];
  assign pc      = exe_bus_r[31:0];

  // A response only counts while a load is actually waiting for it.
  logic data_ok;
  logic mem_ready_go;
  logic ld_pending;

  assign data_ok         = (state == WAIT) && data_sram_data_ok;
  assign mem_ready_go    = !ld_en || (state == HOLD) || data_ok;
  assign mem_allowin     = !mem_valid || (mem_ready_go && wb_allowin);
  assign mem_to_wb_valid = mem_valid && mem_ready_go;
  assign ld_pending      = mem_valid && ld_en && !mem_ready_go;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
      state     <= IDLE;
    end else if (mem_allowin) begin
      mem_valid <= exe_to_mem_valid;
      state     <= (exe_to_mem_valid && exe_to_mem_bus[73]) ? WAIT : IDLE;
    end else if (data_ok) begin
      state <= HOLD;
    end
  end

  // HOLD state is what marks rdata_buf as valid, so the buffer itself needs no reset.
  always_ff @(posedge clk) begin
    if (mem_allowin && exe_to_mem_valid) begin
      exe_bus_r <= exe_to_mem_bus;
    end
    if (data_ok && !wb_allowin) begin
      rdata_buf <= data_sram_rdata;
    end
  end

  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] final_wdata;

  assign ld_word = data_ok ? data_sram_rdata : rdata_buf;

  always_comb begin
    ld_byte     = ld_word[7:0];
    ld_half     = alu_res[1] ? ld_word[31:16] : ld_word[15:0];
    final_wdata = alu_res;
    case (alu_res[1:0])
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      2'd3:    ld_byte = ld_word[31:24];
      default: ld_byte = ld_word[7:0];
    endcase
    if (ld_en) begin
      case (ld_type)
        3'b001:  final_wdata = {{24{ld_byte[7]}}, ld_byte};
        3'b010:  final_wdata = {{16{ld_half[15]}}, ld_half};
        3'b011:  final_wdata = {24'd0, ld_byte};
        3'b100:  final_wdata = {16'd0, ld_half};
        default: final_wdata = ld_word;
      endcase
    end
  end

  assign mem_to_wb_bus = {reg_w, waddr, final_wdata, pc};

  assign mem_to_id_bus = {mem_valid,
                          ld_pending,
                          reg_w && mem_valid,
                          mem_valid ? waddr : 5'd0,
                          (mem_valid && !ld_pending) ? final_wdata : 32'd0};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, load lane
// extraction, late responses, WB back-pressure, back-to-back loads and reset.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        mem_allowin;
  logic        exe_to_mem_valid;
  logic [73:0] exe_to_mem_bus;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [69:0] mem_to_wb_bus;
  logic [39:0] mem_to_id_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int assertCount = 0;
  int failCount   = 0;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .mem_allowin       (mem_allowin),
    .exe_to_mem_valid  (exe_to_mem_valid),
    .exe_to_mem_bus    (exe_to_mem_bus),
    .wb_allowin        (wb_allowin),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .mem_to_id_bus     (mem_to_id_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [73:0] makeInst(input logic ldEn, input logic [2:0] ldType,
                                           input logic regW, input logic [4:0] waddr,
                                           input logic [31:0] alu, input logic [31:0] pc);
    return {ldEn, ldType, regW, waddr, alu, pc};
  endfunction

  task automatic checkOutput(input string tag, input logic [69:0] observed,
                             input logic [69:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge and drive one cycle of inputs.
  task automatic applyStimulus(input logic rstn, input logic exeValid,
                               input logic [73:0] inst, input logic wbAllow,
                               input logic dataOk, input logic [31:0] rdata);
    @(posedge clk);
    #1;
    resetn            = rstn;
    exe_to_mem_valid  = exeValid;
    exe_to_mem_bus    = inst;
    wb_allowin        = wbAllow;
    data_sram_data_ok = dataOk;
    data_sram_rdata   = rdata;
  endtask

  logic [73:0] ldInst [4];
  logic [31:0] ldData [4];
  logic [31:0] ldExp  [4];

  initial begin
    resetn            = 1'b0;
    exe_to_mem_valid  = 1'b0;
    exe_to_mem_bus    = '0;
    wb_allowin        = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    @(negedge clk);
    checkOutput("reset_allowin", 70'(mem_allowin), 70'd1);
    checkOutput("reset_wb_valid", 70'(mem_to_wb_valid), 70'd0);
    checkOutput("reset_id_bus", 70'(mem_to_id_bus), 70'd0);

    // ALU op: one-cycle pass-through, forwarding without stall
    applyStimulus(1'b1, 1'b1, makeInst(1'b0, 3'd0, 1'b1, 5'd5, 32'h1234, 32'h100),
                  1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    @(negedge clk);
    checkOutput("alu_valid", 70'(mem_to_wb_valid), 70'd1);
    checkOutput("alu_wb_bus", 70'(mem_to_wb_bus), {1'b1, 5'd5, 32'h1234, 32'h100});
    checkOutput("alu_id_bus", 70'(mem_to_id_bus), 70'({1'b1, 1'b0, 1'b1, 5'd5, 32'h1234}));

    // ld.b, lane 3, response in the first MEM cycle
    applyStimulus(1'b1, 1'b1, makeInst(1'b1, 3'b001, 1'b1, 5'd7, 32'h2003, 32'h104),
                  1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h80FF_0000);
    @(negedge clk);
    checkOutput("ldb_valid", 70'(mem_to_wb_valid), 70'd1);
    checkOutput("ldb_wdata", 70'(mem_to_wb_bus[63:32]), 70'h FFFF_FF80);
    checkOutput("ldb_pending", 70'(mem_to_id_bus[38]), 70'd0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    @(negedge clk);
    checkOutput("ldb_retired", 70'(mem_to_wb_valid), 70'd0);

    // ld.hu, upper half, response three cycles late
    applyStimulus(1'b1, 1'b1, makeInst(1'b1, 3'b100, 1'b1, 5'd9, 32'h2002, 32'h108),
                  1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'h1111_1111);
      @(negedge clk);
      checkOutput($sformatf("ldhu_pending%0d", i), 70'(mem_to_id_bus[38]), 70'd1);
      checkOutput($sformatf("ldhu_allowin%0d", i), 70'(mem_allowin), 70'd0);
      checkOutput($sformatf("ldhu_valid%0d", i), 70'(mem_to_wb_valid), 70'd0);
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'hBEEF_0000);
    @(negedge clk);
    checkOutput("ldhu_valid", 70'(mem_to_wb_valid), 70'd1);
    checkOutput("ldhu_wdata", 70'(mem_to_wb_bus[63:32]), 70'h0000_BEEF);

    // ld.w with WB blocked: data must survive in the buffer until WB accepts
    applyStimulus(1'b1, 1'b1, makeInst(1'b1, 3'b000, 1'b1, 5'd3, 32'h3000, 32'h300),
                  1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'hCAFE_F00D);
    @(negedge clk);
    checkOutput("hold_enter_valid", 70'(mem_to_wb_valid), 70'd1);
    checkOutput("hold_enter_allowin", 70'(mem_allowin), 70'd0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 32'hDEAD_DEAD);
    @(negedge clk);
    checkOutput("hold_valid", 70'(mem_to_wb_valid), 70'd1);
    checkOutput("hold_wdata", 70'(mem_to_wb_bus[63:32]), 70'hCAFE_F00D);
    checkOutput("hold_allowin", 70'(mem_allowin), 70'd0);
    checkOutput("hold_id_wdata", 70'(mem_to_id_bus[31:0]), 70'hCAFE_F00D);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'hDEAD_DEAD);
    @(negedge clk);
    checkOutput("hold_release_valid", 70'(mem_to_wb_valid), 70'd1);
    checkOutput("hold_release_wdata", 70'(mem_to_wb_bus[63:32]), 70'hCAFE_F00D);
    checkOutput("hold_release_allowin", 70'(mem_allowin), 70'd1);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'hDEAD_DEAD);
    @(negedge clk);
    checkOutput("hold_once", 70'(mem_to_wb_valid), 70'd0);

    // Back-to-back loads with one response per cycle
    ldInst[0] = makeInst(1'b1, 3'b000, 1'b1, 5'd10, 32'h4000, 32'h400);
    ldInst[1] = makeInst(1'b1, 3'b010, 1'b1, 5'd11, 32'h4000, 32'h404);
    ldInst[2] = makeInst(1'b1, 3'b011, 1'b1, 5'd12, 32'h4001, 32'h408);
    ldInst[3] = makeInst(1'b1, 3'b101, 1'b1, 5'd13, 32'h4000, 32'h40C);
    ldData[0] = 32'h1111_2222;  ldExp[0] = 32'h1111_2222;
    ldData[1] = 32'h1234_8765;  ldExp[1] = 32'hFFFF_8765;
    ldData[2] = 32'h0000_AB00;  ldExp[2] = 32'h0000_00AB;
    ldData[3] = 32'h55AA_55AA;  ldExp[3] = 32'h55AA_55AA;
    applyStimulus(1'b1, 1'b1, ldInst[0], 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, (i < 3), (i < 3) ? ldInst[i+1] : 74'd0, 1'b1, 1'b1, ldData[i]);
      @(negedge clk);
      checkOutput($sformatf("b2b_valid%0d", i), 70'(mem_to_wb_valid), 70'd1);
      checkOutput($sformatf("b2b_wdata%0d", i), 70'(mem_to_wb_bus[63:32]), 70'(ldExp[i]));
      checkOutput($sformatf("b2b_pc%0d", i), 70'(mem_to_wb_bus[31:0]), 70'(32'h400 + 32'(4 * i)));
      checkOutput($sformatf("b2b_allowin%0d", i), 70'(mem_allowin), 70'd1);
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    @(negedge clk);
    checkOutput("b2b_drained", 70'(mem_to_wb_valid), 70'd0);

    // Reset while a load waits, then a straggling response
    applyStimulus(1'b1, 1'b1, makeInst(1'b1, 3'b000, 1'b1, 5'd14, 32'h5000, 32'h500),
                  1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("rst_stray_valid", 70'(mem_to_wb_valid), 70'd0);
    checkOutput("rst_stray_allowin", 70'(mem_allowin), 70'd1);
    checkOutput("rst_stray_id_bus", 70'(mem_to_id_bus), 70'd0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    @(negedge clk);
    checkOutput("rst_idle_valid", 70'(mem_to_wb_valid), 70'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
